// File: rtl/ewrapper_tx_serializer.sv
// Parallel-to-DDR lane serializer: a one-word staging register feeds per-lane
// 2-bit-per-cycle shifters that drive the ODDR D1/D2 pins directly.

module ewrapper_tx_lane #(
  parameter int RATIO     = 8,
  parameter int LSB_FIRST = 0,
  parameter int INVERT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [RATIO-1:0] word,
  output logic             even,
  output logic             odd
);
  localparam logic INV = (INVERT != 0);

  logic [RATIO-1:0] sh;

  // The head pair always sits at one end, so the pins are plain flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sh <= '0;
    else if (load)           sh <= word;
    else if (LSB_FIRST != 0) sh <= sh >> 2;
    else                     sh <= sh << 2;
  end

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign even = sh[0] ^ INV;
      assign odd  = sh[1] ^ INV;
    end else begin : g_msb
      assign even = sh[RATIO-1] ^ INV;
      assign odd  = sh[RATIO-2] ^ INV;
    end
  endgenerate
endmodule

module ewrapper_tx_serializer #(
  parameter int               LANES     = 9,
  parameter int               RATIO     = 8,
  parameter int               LSB_FIRST = 0,
  parameter int               INVERT    = 0,
  parameter logic [RATIO-1:0] TRAIN_PAT = {RATIO/2{2'b10}}
) (
  input  logic                   CLK_IN,
  input  logic                   CLK_RESET,
  input  logic [LANES*RATIO-1:0] DATA_IN,
  input  logic                   DATA_VALID,
  output logic                   DATA_READY,
  input  logic                   TRAIN_EN,
  output logic [LANES-1:0]       EVEN_OUT,
  output logic [LANES-1:0]       ODD_OUT,
  output logic                   FRAME_OUT,
  output logic                   DVALID_OUT,
  output logic                   UNDERRUN
);
  localparam int             HALF = RATIO / 2;
  localparam int             CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]  LAST = CW'(HALF - 1);

  logic [CW-1:0]          cnt;
  logic                   load_point;
  logic                   xfer;
  logic                   stg_full;
  logic [LANES*RATIO-1:0] stg;
  logic [LANES*RATIO-1:0] fill;
  logic [LANES*RATIO-1:0] load_word;

  assign load_point = (cnt == LAST);
  assign DATA_READY = ~stg_full | load_point;
  assign xfer       = DATA_VALID & DATA_READY;
  assign fill       = TRAIN_EN ? {LANES{TRAIN_PAT}} : '0;
  assign load_word  = stg_full ? stg : fill;

  // Beat counter never stalls; slot boundaries are fixed relative to reset.
  always_ff @(posedge CLK_IN or posedge CLK_RESET) begin
    if (CLK_RESET)       cnt <= '0;
    else if (load_point) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  always_ff @(posedge CLK_IN or posedge CLK_RESET) begin
    if (CLK_RESET) begin
      stg        <= '0;
      stg_full   <= 1'b0;
      FRAME_OUT  <= 1'b0;
      DVALID_OUT <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      // A transfer on the load edge refills the slot the shifter just emptied.
      if (xfer) begin
        stg      <= DATA_IN;
        stg_full <= 1'b1;
      end else if (load_point) begin
        stg_full <= 1'b0;
      end
      FRAME_OUT <= load_point;
      UNDERRUN  <= load_point & ~stg_full & DVALID_OUT;
      if (load_point) DVALID_OUT <= stg_full;
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      ewrapper_tx_lane #(
        .RATIO    (RATIO),
        .LSB_FIRST(LSB_FIRST),
        .INVERT   (INVERT)
      ) u_lane (
        .clk (CLK_IN),
        .rst (CLK_RESET),
        .load(load_point),
        .word(load_word[l*RATIO +: RATIO]),
        .even(EVEN_OUT[l]),
        .odd (ODD_OUT[l])
      );
    end
  endgenerate
endmodule

// File: tb/tb_ewrapper_tx_serializer.sv
// Bench for ewrapper_tx_serializer: three configurations checked every cycle
// against a slot-level model, plus hand-computed literal expectations.

module tb_ewrapper_tx_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        train = 1'b0;
  logic        valid [3];
  logic [71:0] data  [3];

  logic       rdy0, fr0, dv0, un0;
  logic [8:0] ev0, od0;
  logic       rdy1, fr1, dv1, un1;
  logic [1:0] ev1, od1;
  logic       rdy2, fr2, dv2, un2;
  logic [1:0] ev2, od2;

  int tests = 0;
  int fails = 0;
  int un_cnt = 0;

  always #5 clk = ~clk;

  ewrapper_tx_serializer u0 (
    .CLK_IN(clk), .CLK_RESET(rst), .DATA_IN(data[0]), .DATA_VALID(valid[0]),
    .DATA_READY(rdy0), .TRAIN_EN(train), .EVEN_OUT(ev0), .ODD_OUT(od0),
    .FRAME_OUT(fr0), .DVALID_OUT(dv0), .UNDERRUN(un0));

  ewrapper_tx_serializer #(.LANES(2), .RATIO(4), .LSB_FIRST(1)) u1 (
    .CLK_IN(clk), .CLK_RESET(rst), .DATA_IN(data[1][7:0]), .DATA_VALID(valid[1]),
    .DATA_READY(rdy1), .TRAIN_EN(train), .EVEN_OUT(ev1), .ODD_OUT(od1),
    .FRAME_OUT(fr1), .DVALID_OUT(dv1), .UNDERRUN(un1));

  ewrapper_tx_serializer #(.LANES(2), .INVERT(1)) u2 (
    .CLK_IN(clk), .CLK_RESET(rst), .DATA_IN(data[2][15:0]), .DATA_VALID(valid[2]),
    .DATA_READY(rdy2), .TRAIN_EN(train), .EVEN_OUT(ev2), .ODD_OUT(od2),
    .FRAME_OUT(fr2), .DVALID_OUT(dv2), .UNDERRUN(un2));

  function automatic int rat(int i); return (i == 1) ? 4 : 8; endfunction
  function automatic int lan(int i); return (i == 0) ? 9 : 2; endfunction
  function automatic bit lsb(int i); return (i == 1); endfunction
  function automatic bit inv(int i); return (i == 2); endfunction

  // Slot-level model: edges since reset, one staged word, word on the wire.
  int          n     [3];
  int          beat  [3];
  logic [71:0] cur   [3];
  logic [71:0] stg   [3];
  bit          stg_v [3];
  bit          cur_d [3];
  bit          m_fr  [3];
  bit          m_dv  [3];
  bit          m_un  [3];

  function automatic bit m_ready(int i);
    return !stg_v[i] || ((n[i] + 1) % (rat(i) / 2) == 0);
  endfunction

  function automatic logic [71:0] fill_word(int i, bit t);
    logic [71:0] w = '0;
    for (int j = 0; j < rat(i) * lan(i); j++) w[j] = t && (j % 2 == 1);
    return w;
  endfunction

  function automatic logic [8:0] exp_vec(int i, bit odd);
    logic [8:0] v = '0;
    int r = rat(i);
    int idx;
    if (beat[i] < r / 2) begin
      for (int l = 0; l < lan(i); l++) begin
        if (lsb(i)) idx = l * r + 2 * beat[i] + (odd ? 1 : 0);
        else        idx = l * r + r - 1 - 2 * beat[i] - (odd ? 1 : 0);
        v[l] = cur[i][idx] ^ inv(i);
      end
    end else begin
      for (int l = 0; l < lan(i); l++) v[l] = inv(i);
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        n[i] = 0; beat[i] = 0; cur[i] = '0; stg[i] = '0; stg_v[i] = 0;
        cur_d[i] = 0; m_fr[i] = 0; m_dv[i] = 0; m_un[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit ld;
        bit xf;
        ld = ((n[i] + 1) % (rat(i) / 2) == 0);
        xf = valid[i] && m_ready(i);
        if (ld) begin
          m_un[i] = !stg_v[i] && cur_d[i];
          if (stg_v[i]) begin cur[i] = stg[i]; cur_d[i] = 1; end
          else begin cur[i] = fill_word(i, train); cur_d[i] = 0; end
          beat[i] = 0;
          m_fr[i] = 1;
          m_dv[i] = cur_d[i];
        end else begin
          beat[i] = beat[i] + 1;
          m_fr[i] = 0;
          m_un[i] = 0;
        end
        if (xf) begin stg[i] = data[i]; stg_v[i] = 1; end
        else if (ld) stg_v[i] = 0;
        n[i] = n[i] + 1;
      end
    end
  end

  // Per-cycle compare of every output of every instance against the model.
  always @(negedge clk) begin
    if (un0) un_cnt++;
    for (int i = 0; i < 3; i++) begin
      logic [21:0] act;
      logic [21:0] expv;
      case (i)
        0:       act = {rdy0, ev0, od0, fr0, dv0, un0};
        1:       act = {rdy1, 7'b0, ev1, 7'b0, od1, fr1, dv1, un1};
        default: act = {rdy2, 7'b0, ev2, 7'b0, od2, fr2, dv2, un2};
      endcase
      expv = {m_ready(i), exp_vec(i, 0), exp_vec(i, 1), m_fr[i], m_dv[i], m_un[i]};
      tests++;
      if (act !== expv) begin
        fails++;
        $display("FAIL model_u%0d t=%0t: got %h want %h (rdy,even,odd,frame,dvalid,underrun)",
                 i, $time, act, expv);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_ready0();
    int t = 0;
    while (!rdy0 && t < 20) begin @(negedge clk); t++; end
    chk("ready_timeout", 32'(rdy0), 32'd1);
  endtask

  time acc [16];

  initial begin
    for (int i = 0; i < 3; i++) begin valid[i] = 1'b0; data[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_ready",    32'(rdy0), 32'd1);
    chk("rst_even",     32'(ev0),  32'h0);
    chk("rst_odd",      32'(od0),  32'h0);
    chk("rst_frame",    32'(fr0),  32'd0);
    chk("rst_inv_even", 32'(ev2),  32'h3);
    chk("rst_inv_odd",  32'(od2),  32'h3);

    // First slot after reset: lane words A5 on u0, 1E on the LSB-first u1.
    data[0] = {9{8'hA5}}; valid[0] = 1'b1;
    data[1] = {64'h0, 8'h1E}; valid[1] = 1'b1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("a5_b0_even", 32'(ev0), 32'h1FF); chk("a5_b0_odd", 32'(od0), 32'h0);
    chk("a5_b0_frame", 32'(fr0), 32'd1);  chk("a5_b0_dval", 32'(dv0), 32'd1);
    chk("lsb_b0_even", 32'(ev1), 32'h2);  chk("lsb_b0_odd", 32'(od1), 32'h1);
    @(negedge clk);
    chk("a5_b1_even", 32'(ev0), 32'h1FF); chk("a5_b1_odd", 32'(od0), 32'h0);
    chk("a5_b1_frame", 32'(fr0), 32'd0);
    chk("lsb_b1_even", 32'(ev1), 32'h1);  chk("lsb_b1_odd", 32'(od1), 32'h1);
    chk("inv_zero_even", 32'(ev2), 32'h3); chk("inv_zero_odd", 32'(od2), 32'h3);
    @(negedge clk);
    chk("a5_b2_even", 32'(ev0), 32'h0);   chk("a5_b2_odd", 32'(od0), 32'h1FF);
    @(negedge clk);
    chk("a5_b3_even", 32'(ev0), 32'h0);   chk("a5_b3_odd", 32'(od0), 32'h1FF);
    chk("a5_b3_dval", 32'(dv0), 32'd1);

    // Back-to-back stream of 16 distinct words.
    un_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 9; l++) data[0][l*8 +: 8] = 8'(i * 16 + l);
      wait_ready0();
      @(posedge clk); acc[i] = $time; #1;
    end
    for (int i = 1; i < 16; i++) chk("stream_spacing", 32'(acc[i] - acc[i-1]), 32'd40);

    // One more data word, then starve with training fill enabled.
    train = 1'b1;
    data[0] = {9{8'h3C}};
    wait_ready0();
    @(posedge clk); #1;
    valid[0] = 1'b0;
    chk("stream_no_underrun", 32'(un_cnt), 32'd0);
    repeat (5) @(negedge clk);
    chk("3c_b0_even", 32'(ev0), 32'h0); chk("3c_b0_odd", 32'(od0), 32'h0);
    chk("3c_b0_dval", 32'(dv0), 32'd1); chk("3c_b0_frame", 32'(fr0), 32'd1);
    repeat (4) @(negedge clk);
    chk("fill_underrun", 32'(un0), 32'd1); chk("fill_frame", 32'(fr0), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("train_even", 32'(ev0), 32'h1FF); chk("train_odd", 32'(od0), 32'h0);
      chk("train_dval", 32'(dv0), 32'd0);
      @(negedge clk);
    end
    chk("underrun_count", 32'(un_cnt), 32'd1);

    // Reset mid-slot with the staging register full.
    train = 1'b0;
    data[0] = {9{8'h5A}}; valid[0] = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_rst_dval", 32'(dv0), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_even", 32'(ev0), 32'h0);  chk("arst_odd", 32'(od0), 32'h0);
    chk("arst_frame", 32'(fr0), 32'd0); chk("arst_dval", 32'(dv0), 32'd0);
    chk("arst_ready", 32'(rdy0), 32'd1); chk("arst_inv_even", 32'(ev2), 32'h3);
    valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("no_remnant_even", 32'(ev0), 32'h0); chk("no_remnant_odd", 32'(od0), 32'h0);
      chk("no_remnant_dval", 32'(dv0), 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
